timer_irq_service_master: RTL and testbench
===========================================

Name: timer_irq_service_master

Overview:
- Avalon-MM master that drives the s1 slave port of the interval timer (3-bit address, 16-bit data, chipselect/write_n, fixed read latency 1, no waitrequest).
- Enables the timer interrupt, services each timeout by reading and clearing the status register, and counts ticks.
- Lets fabric logic use the periodic timer without a CPU; sits beside the timer in the Qsys system.

Parameters:
- TICK_W, 32, width of tick_count; wraps modulo 2^TICK_W.
- STATUS_ADDR, 0, timer status register address.
- CTRL_ADDR, 1, timer control register address.
- PERIODL_ADDR, 2, timer period-low address; any write forces a counter reload.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  level; 1 = interrupt enabled and serviced, 0 = disabled.
- restart  in  1  single-cycle pulse; request a timer reload.
- irq  in  1  timer interrupt.
- address  out  3  to timer s1.
- chipselect  out  1  to timer s1.
- write_n  out  1  to timer s1, active-low write.
- writedata  out  16  to timer s1.
- readdata  in  16  from timer s1; valid the cycle after the address is presented.
- tick_pulse  out  1  one-cycle pulse per serviced timeout.
- tick_count  out  TICK_W  serviced timeouts.
- spurious_count  out  8  irq services whose status bit0 was 0; saturates at 255.
- busy  out  1  FSM not in IDLE or WAIT_IRQ.

Behaviour:
- Reset values:
  - address=0, chipselect=0, write_n=1, writedata=0.
  - tick_pulse=0, tick_count=0, spurious_count=0, busy=0.
  - Internal flags en_q=0, restart_pend=0; state IDLE.
- All bus outputs are registered. A transfer occupies exactly one cycle with chipselect=1. Between transfers: chipselect=0, write_n=1.
- FSM states: IDLE, WR_CTRL, WAIT_IRQ, RD_STATUS, RD_CAPT, WR_CLR, SETTLE, WR_RELOAD.
- IDLE:
  - en=1 → WR_CTRL with writedata=1.
  - restart_pend → WR_RELOAD.
- WR_CTRL:
  - Drives CTRL_ADDR, write_n=0, writedata=en_q, for 1 cycle.
  - Next state: WAIT_IRQ if en_q, else IDLE.
- WAIT_IRQ, priority order:
  1. irq=1 → RD_STATUS.
  2. en=0 → WR_CTRL with writedata=0.
  3. restart_pend → WR_RELOAD.
- RD_STATUS: drives STATUS_ADDR, write_n=1 → RD_CAPT.
- RD_CAPT: samples readdata[0].
  - If 1: tick_count+1 and tick_pulse=1 on the next cycle.
  - If 0: spurious_count+1, saturating.
  - Always → WR_CLR.
- WR_CLR: write STATUS_ADDR with writedata=0 → SETTLE.
- SETTLE:
  - One dead cycle; the timer drops irq on the edge after the clear, so irq is ignored here.
  - Next: WAIT_IRQ, or WR_CTRL (writedata=0) if en=0.
- WR_RELOAD: write PERIODL_ADDR with writedata=0; clear restart_pend; return to the state it came from (IDLE or WAIT_IRQ).
- restart_pend:
  - Set by a restart pulse in any state; cleared only in WR_RELOAD.
  - Multiple pulses before service coalesce into one reload.
- Latency: irq rising in WAIT_IRQ → tick_pulse 4 cycles later (edges: RD_STATUS, RD_CAPT, WR_CLR, pulse).
- Simultaneous events:
  - irq beats en-drop beats restart.
  - An en drop during service completes the service first, then disables.
- irq asserted in IDLE (interrupt disabled) is ignored.
- tick_count wraps from all-ones to 0 without a flag.
- Reset mid-transfer returns all outputs to reset values immediately (asynchronous). The timer's own control register is not restored; re-enable via en.

Decomposition:
- Package timer_master_pkg holds:
  - the state enum;
  - STATUS_ADDR/CTRL_ADDR/PERIODL_ADDR defaults;
  - status bit index TO_BIT=0;
  - control bit index ITO_BIT=0.
- One sub-module, avmm_single_master: issues one-cycle read/write strobes with registered outputs and a one-cycle read-capture valid. The FSM stays in the top.

Test Plan:
- Reset: hold reset 3 cycles → all outputs at reset values; no chipselect for 5 cycles with en=0.
- Enable: en 0→1 → next cycle address=1, chipselect=1, write_n=0, writedata=1 for exactly 1 cycle; busy=1 in that cycle.
- Timeout: model slave with readdata[0]=1, irq high in WAIT_IRQ →
  - read of addr 0, then write of addr 0 with data 0;
  - tick_pulse 4 cycles after irq; tick_count 0→1.
  - 300 repetitions → tick_count=300.
- Spurious: readdata[0]=0 on service → spurious_count=1, tick_count unchanged, clear write still issued. Repeat 260 times → spurious_count=255.
- Restart collision: restart pulse in the same cycle irq rises → service sequence first, then one write to addr 2. A second restart during service still yields exactly one addr-2 write.
- Disable/reset: en drops during RD_CAPT → service completes, then write addr 1 data 0, then IDLE. Assert reset mid-WR_CLR → chipselect=0 in the same cycle.

Source files
------------

// File: rtl/timer_master_pkg.sv
`default_nettype none
// ============================================================================
// Module   : timer_master_pkg
// Brief    : Shared state encoding and register map for the timer IRQ master.
// Revision : 1.0
// ============================================================================
package timer_master_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WR_CTRL   = 3'd1,
        S_WAIT_IRQ  = 3'd2,
        S_RD_STATUS = 3'd3,
        S_RD_CAPT   = 3'd4,
        S_WR_CLR    = 3'd5,
        S_SETTLE    = 3'd6,
        S_WR_RELOAD = 3'd7
    } state_t;

    localparam logic [2:0] c_status_addr  = 3'd0;
    localparam logic [2:0] c_ctrl_addr    = 3'd1;
    localparam logic [2:0] c_periodl_addr = 3'd2;

    // TO in the status register, ITO in the control register
    localparam int c_to_bit  = 0;
    localparam int c_ito_bit = 0;

endpackage
`default_nettype wire

// File: rtl/timer_irq_service_master_if.sv
`default_nettype none
// ============================================================================
// Module   : timer_irq_service_master_if
// Brief    : Avalon-MM link to the interval timer s1 slave port.
// Revision : 1.0
// ============================================================================
interface timer_irq_service_master_if;

    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );

endinterface
`default_nettype wire

// File: rtl/avmm_single_master.sv
`default_nettype none
// ============================================================================
// Module   : avmm_single_master
// Brief    : One-cycle registered read/write strobes, latency-1 read capture.
// Revision : 1.0
// ============================================================================
module avmm_single_master (
    input  wire         clk,
    input  wire         reset,
    input  wire         req_valid,
    input  wire         req_write,
    input  wire  [2:0]  req_addr,
    input  wire  [15:0] req_wdata,
    output logic        rd_valid,
    output logic [15:0] rd_data,
    timer_irq_service_master_if.master bus
);

    logic r_cap;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.address    <= 3'd0;
            bus.chipselect <= 1'b0;
            bus.write_n    <= 1'b1;
            bus.writedata  <= 16'd0;
            r_cap          <= 1'b0;
            rd_valid       <= 1'b0;
            rd_data        <= 16'd0;
        end else begin
            bus.chipselect <= req_valid;
            bus.write_n    <= !(req_valid && req_write);
            if (req_valid) begin
                bus.address <= req_addr;
                if (req_write) begin
                    bus.writedata <= req_wdata;
                end
            end
            // readdata is valid the cycle after the read strobe
            r_cap    <= bus.chipselect && bus.write_n;
            rd_valid <= r_cap;
            if (r_cap) begin
                rd_data <= bus.readdata;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/timer_irq_service_master.sv
`default_nettype none
// ============================================================================
// Module   : timer_irq_service_master
// Brief    : Enables the interval timer IRQ, services timeouts, counts ticks.
// Revision : 1.0
// ============================================================================
module timer_irq_service_master
    import timer_master_pkg::*;
#(
    parameter int         TICK_W       = 32,
    parameter logic [2:0] STATUS_ADDR  = c_status_addr,
    parameter logic [2:0] CTRL_ADDR    = c_ctrl_addr,
    parameter logic [2:0] PERIODL_ADDR = c_periodl_addr
) (
    input  wire                clk,
    input  wire                reset,
    input  wire                en,
    input  wire                restart,
    input  wire                irq,
    timer_irq_service_master_if.master bus,
    output logic               tick_pulse,
    output logic [TICK_W-1:0]  tick_count,
    output logic [7:0]         spurious_count,
    output logic               busy
);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_en_q;
    logic        w_en_q_nxt;
    logic        r_restart_pend;
    logic        r_ret_wait;
    logic        w_req_valid;
    logic        w_req_write;
    logic [2:0]  w_req_addr;
    logic [15:0] w_req_wdata;
    logic        w_rd_valid;
    logic [15:0] w_rd_data;
    logic        w_unused_rd;

    assign w_unused_rd = ^w_rd_data;
    assign busy        = (r_state != S_IDLE) && (r_state != S_WAIT_IRQ);

    always_comb begin
        w_state_nxt = r_state;
        w_en_q_nxt  = r_en_q;
        w_req_valid = 1'b0;
        w_req_write = 1'b0;
        w_req_addr  = STATUS_ADDR;
        w_req_wdata = 16'd0;

        case (r_state)
            S_IDLE: begin
                if (en) begin
                    w_state_nxt = S_WR_CTRL;
                    w_en_q_nxt  = 1'b1;
                end else if (r_restart_pend) begin
                    w_state_nxt = S_WR_RELOAD;
                end
            end
            S_WR_CTRL:   w_state_nxt = r_en_q ? S_WAIT_IRQ : S_IDLE;
            S_WAIT_IRQ: begin
                if (irq) begin
                    w_state_nxt = S_RD_STATUS;
                end else if (!en) begin
                    w_state_nxt = S_WR_CTRL;
                    w_en_q_nxt  = 1'b0;
                end else if (r_restart_pend) begin
                    w_state_nxt = S_WR_RELOAD;
                end
            end
            S_RD_STATUS: w_state_nxt = S_RD_CAPT;
            S_RD_CAPT:   w_state_nxt = S_WR_CLR;
            S_WR_CLR:    w_state_nxt = S_SETTLE;
            // irq is still high here; the timer drops it on the following edge
            S_SETTLE: begin
                if (!en) begin
                    w_state_nxt = S_WR_CTRL;
                    w_en_q_nxt  = 1'b0;
                end else begin
                    w_state_nxt = S_WAIT_IRQ;
                end
            end
            S_WR_RELOAD: w_state_nxt = r_ret_wait ? S_WAIT_IRQ : S_IDLE;
            default:     w_state_nxt = S_IDLE;
        endcase

        // Bus states never self-loop, so the strobe is launched on entry
        case (w_state_nxt)
            S_WR_CTRL: begin
                w_req_valid = 1'b1;
                w_req_write = 1'b1;
                w_req_addr  = CTRL_ADDR;
                w_req_wdata[c_ito_bit] = w_en_q_nxt;
            end
            S_RD_STATUS: begin
                w_req_valid = 1'b1;
                w_req_addr  = STATUS_ADDR;
            end
            S_WR_CLR: begin
                w_req_valid = 1'b1;
                w_req_write = 1'b1;
                w_req_addr  = STATUS_ADDR;
            end
            S_WR_RELOAD: begin
                w_req_valid = 1'b1;
                w_req_write = 1'b1;
                w_req_addr  = PERIODL_ADDR;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_en_q         <= 1'b0;
            r_restart_pend <= 1'b0;
            r_ret_wait     <= 1'b0;
            tick_pulse     <= 1'b0;
            tick_count     <= '0;
            spurious_count <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_en_q  <= w_en_q_nxt;

            if (restart) begin
                r_restart_pend <= 1'b1;
            end else if (r_state == S_WR_RELOAD) begin
                r_restart_pend <= 1'b0;
            end

            if (w_state_nxt == S_WR_RELOAD) begin
                r_ret_wait <= (r_state == S_WAIT_IRQ);
            end

            tick_pulse <= w_rd_valid && w_rd_data[c_to_bit];
            if (w_rd_valid) begin
                if (w_rd_data[c_to_bit]) begin
                    tick_count <= tick_count + TICK_W'(1);
                end else if (spurious_count != 8'hFF) begin
                    spurious_count <= spurious_count + 8'd1;
                end
            end
        end
    end

    avmm_single_master u_avmm (
        .clk       (clk),
        .reset     (reset),
        .req_valid (w_req_valid),
        .req_write (w_req_write),
        .req_addr  (w_req_addr),
        .req_wdata (w_req_wdata),
        .rd_valid  (w_rd_valid),
        .rd_data   (w_rd_data),
        .bus       (bus)
    );

endmodule
`default_nettype wire

// File: tb/tb_timer_irq_service_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_timer_irq_service_master
// Brief    : Self-checking bench with an interval-timer slave model.
// Revision : 1.0
// ============================================================================
module tb_timer_irq_service_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        restart;
    logic        irq;
    logic        tick_pulse;
    logic [31:0] tick_count;
    logic [7:0]  spurious_count;
    logic        busy;
    logic        tick_pulse4;
    logic [3:0]  tick_count4;
    logic [7:0]  spurious_count4;
    logic        busy4;

    timer_irq_service_master_if bus ();
    timer_irq_service_master_if bus4 ();

    timer_irq_service_master #(.TICK_W(32)) dut (
        .clk(clk), .reset(reset), .en(en), .restart(restart), .irq(irq), .bus(bus),
        .tick_pulse(tick_pulse), .tick_count(tick_count),
        .spurious_count(spurious_count), .busy(busy)
    );

    // Narrow-counter copy exercises the modulo wrap of tick_count
    timer_irq_service_master #(.TICK_W(4)) dut4 (
        .clk(clk), .reset(reset), .en(en), .restart(restart), .irq(irq), .bus(bus4),
        .tick_pulse(tick_pulse4), .tick_count(tick_count4),
        .spurious_count(spurious_count4), .busy(busy4)
    );
    assign bus4.readdata = bus.readdata;

    always #5 clk = ~clk;

    // Interval timer slave model
    logic s_to = 1'b0, s_force = 1'b0, s_ito = 1'b0;
    logic fire_to, fire_spur, irq_stuck;
    assign irq = (s_ito & (s_to | s_force)) | irq_stuck;

    always @(posedge clk) begin
        if (fire_to)   s_to    <= 1'b1;
        if (fire_spur) s_force <= 1'b1;
        if (bus.chipselect) begin
            if (!bus.write_n) begin
                if (bus.address == 3'd0) begin
                    s_to    <= 1'b0;
                    s_force <= 1'b0;
                end else if (bus.address == 3'd1) begin
                    s_ito <= bus.writedata[0];
                end
            end else begin
                bus.readdata <= (bus.address == 3'd0) ? {15'd0, s_to} : 16'd0;
            end
        end
    end

    typedef struct packed {
        logic [2:0]  a;
        logic        wn;
        logic [15:0] d;
    } tx_t;

    tx_t txq[$];
    logic cs_prev = 1'b0;
    int   cs_violations = 0;

    always @(negedge clk) begin
        if (bus.chipselect) begin
            txq.push_back('{a: bus.address, wn: bus.write_n, d: bus.writedata});
            if (cs_prev) cs_violations <= cs_violations + 1;
        end
        cs_prev <= bus.chipselect;
    end

    int n_checks = 0;
    int n_pass   = 0;
    int m_ticks  = 0;
    int m_spur   = 0;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; en = 1'b0; restart = 1'b0;
        fire_to = 1'b0; fire_spur = 1'b0; irq_stuck = 1'b0;
        cyc(3);
        n_checks++;
        if ({bus.address, bus.chipselect, bus.write_n, bus.writedata} !== {3'd0, 1'b0, 1'b1, 16'd0})
            $display("FAIL reset_bus got a=%0d cs=%b wn=%b d=%h exp a=0 cs=0 wn=1 d=0",
                     bus.address, bus.chipselect, bus.write_n, bus.writedata);
        else n_pass++;
        n_checks++;
        if ({tick_pulse, tick_count, spurious_count, busy} !== {1'b0, 32'd0, 8'd0, 1'b0})
            $display("FAIL reset_out got p=%b tc=%0d sc=%0d busy=%b exp all 0",
                     tick_pulse, tick_count, spurious_count, busy);
        else n_pass++;
        reset = 1'b0;
        txq.delete();
        cyc(5);
        n_checks++;
        if (txq.size() !== 0) $display("FAIL reset_quiet got %0d transfers exp 0", txq.size());
        else n_pass++;
    endtask

    task automatic test_enable;
        txq.delete();
        en = 1'b1;
        cyc(1);
        n_checks++;
        if ({bus.chipselect, bus.address, bus.write_n, bus.writedata, busy} !== {1'b1, 3'd1, 1'b0, 16'd1, 1'b1})
            $display("FAIL enable_wr got cs=%b a=%0d wn=%b d=%h busy=%b exp cs=1 a=1 wn=0 d=1 busy=1",
                     bus.chipselect, bus.address, bus.write_n, bus.writedata, busy);
        else n_pass++;
        cyc(1);
        n_checks++;
        if ({bus.chipselect, bus.write_n, busy} !== {1'b0, 1'b1, 1'b0})
            $display("FAIL enable_end got cs=%b wn=%b busy=%b exp cs=0 wn=1 busy=0",
                     bus.chipselect, bus.write_n, busy);
        else n_pass++;
    endtask

    // Fires one timeout (genuine or spurious) while waiting and checks the service
    task automatic do_service(input bit genuine);
        txq.delete();
        if (genuine) fire_to = 1'b1; else fire_spur = 1'b1;
        cyc(1);
        fire_to = 1'b0; fire_spur = 1'b0;
        cyc(3);
        n_checks++;
        if (tick_pulse !== 1'b0) $display("FAIL pulse_early got %b exp 0", tick_pulse);
        else n_pass++;
        cyc(1);
        if (genuine) m_ticks++;
        else if (m_spur < 255) m_spur++;
        n_checks++;
        if (tick_pulse !== genuine) $display("FAIL pulse got %b exp %b", tick_pulse, genuine);
        else n_pass++;
        n_checks++;
        if (tick_count !== 32'(m_ticks) || spurious_count !== 8'(m_spur) || tick_count4 !== 4'(m_ticks))
            $display("FAIL counts got tc=%0d sc=%0d tc4=%0d exp tc=%0d sc=%0d tc4=%0d",
                     tick_count, spurious_count, tick_count4, m_ticks, m_spur, m_ticks % 16);
        else n_pass++;
        cyc(1);
        n_checks++;
        if (busy !== 1'b0 || txq.size() != 2 || txq[0].a != 3'd0 || txq[0].wn != 1'b1 ||
            txq[1] != '{a: 3'd0, wn: 1'b0, d: 16'd0})
            $display("FAIL service_bus got busy=%b ntx=%0d exp busy=0 ntx=2 (read 0, write 0 data 0)",
                     busy, txq.size());
        else n_pass++;
    endtask

    task automatic test_timeout;
        for (int i = 0; i < 300; i++) begin
            do_service(1'b1);
            cyc($urandom_range(0, 3));
        end
        n_checks++;
        if (tick_count !== 32'd300 || tick_count4 !== 4'd12)
            $display("FAIL timeout_total got tc=%0d tc4=%0d exp 300 12", tick_count, tick_count4);
        else n_pass++;
    endtask

    task automatic test_restart_collision;
        txq.delete();
        fire_to = 1'b1;
        cyc(1);
        fire_to = 1'b0;
        restart = 1'b1;
        cyc(1);
        restart = 1'b0;
        cyc(1);
        restart = 1'b1;
        cyc(1);
        restart = 1'b0;
        cyc(10);
        m_ticks++;
        n_checks++;
        if (txq.size() != 3 || txq[0].a != 3'd0 || txq[0].wn != 1'b1 ||
            txq[1] != '{a: 3'd0, wn: 1'b0, d: 16'd0} || txq[2] != '{a: 3'd2, wn: 1'b0, d: 16'd0})
            $display("FAIL collision_bus got ntx=%0d exp 3 (read 0, clear, one reload)", txq.size());
        else n_pass++;
        n_checks++;
        if (tick_count !== 32'(m_ticks) || busy !== 1'b0)
            $display("FAIL collision_cnt got tc=%0d busy=%b exp tc=%0d busy=0", tick_count, busy, m_ticks);
        else n_pass++;
    endtask

    task automatic test_random_mix;
        for (int i = 0; i < 60; i++) begin
            do_service(1'($urandom_range(0, 1)));
            cyc($urandom_range(0, 4));
        end
    endtask

    task automatic test_spurious;
        int ticks_before;
        ticks_before = m_ticks;
        for (int i = 0; i < 260; i++) begin
            do_service(1'b0);
            cyc($urandom_range(0, 2));
        end
        n_checks++;
        if (spurious_count !== 8'd255 || tick_count !== 32'(ticks_before))
            $display("FAIL spurious_sat got sc=%0d tc=%0d exp sc=255 tc=%0d",
                     spurious_count, tick_count, ticks_before);
        else n_pass++;
    endtask

    task automatic test_disable;
        txq.delete();
        fire_to = 1'b1;
        cyc(1);
        fire_to = 1'b0;
        cyc(2);
        en = 1'b0;
        cyc(6);
        m_ticks++;
        n_checks++;
        if (txq.size() != 3 || txq[0].a != 3'd0 || txq[0].wn != 1'b1 ||
            txq[1] != '{a: 3'd0, wn: 1'b0, d: 16'd0} || txq[2] != '{a: 3'd1, wn: 1'b0, d: 16'd0})
            $display("FAIL disable_bus got ntx=%0d exp 3 (read 0, clear, ctrl 0)", txq.size());
        else n_pass++;
        n_checks++;
        if (tick_count !== 32'(m_ticks) || busy !== 1'b0)
            $display("FAIL disable_state got tc=%0d busy=%b exp tc=%0d busy=0", tick_count, busy, m_ticks);
        else n_pass++;
        cyc(4);
        n_checks++;
        if (txq.size() != 3) $display("FAIL disable_quiet got ntx=%0d exp 3", txq.size());
        else n_pass++;
    endtask

    task automatic test_idle;
        txq.delete();
        irq_stuck = 1'b1;
        cyc(5);
        irq_stuck = 1'b0;
        n_checks++;
        if (txq.size() != 0 || busy !== 1'b0 || tick_count !== 32'(m_ticks))
            $display("FAIL idle_irq got ntx=%0d busy=%b tc=%0d exp 0 0 %0d", txq.size(), busy, tick_count, m_ticks);
        else n_pass++;
        restart = 1'b1;
        cyc(1);
        restart = 1'b0;
        cyc(1);
        n_checks++;
        if ({bus.chipselect, bus.address, bus.write_n, bus.writedata, busy} !== {1'b1, 3'd2, 1'b0, 16'd0, 1'b1})
            $display("FAIL idle_reload got cs=%b a=%0d wn=%b d=%h busy=%b exp cs=1 a=2 wn=0 d=0 busy=1",
                     bus.chipselect, bus.address, bus.write_n, bus.writedata, busy);
        else n_pass++;
        cyc(4);
        n_checks++;
        if (txq.size() != 1 || busy !== 1'b0)
            $display("FAIL idle_after got ntx=%0d busy=%b exp 1 0", txq.size(), busy);
        else n_pass++;
    endtask

    task automatic test_reset_mid;
        en = 1'b1;
        cyc(2);
        fire_to = 1'b1;
        cyc(1);
        fire_to = 1'b0;
        cyc(3);
        n_checks++;
        if ({bus.chipselect, bus.address, bus.write_n} !== {1'b1, 3'd0, 1'b0})
            $display("FAIL mid_wrclr got cs=%b a=%0d wn=%b exp cs=1 a=0 wn=0",
                     bus.chipselect, bus.address, bus.write_n);
        else n_pass++;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({bus.chipselect, bus.write_n, bus.address, bus.writedata, busy, tick_count, spurious_count} !==
            {1'b0, 1'b1, 3'd0, 16'd0, 1'b0, 32'd0, 8'd0})
            $display("FAIL mid_reset got cs=%b wn=%b a=%0d busy=%b tc=%0d sc=%0d exp 0 1 0 0 0 0",
                     bus.chipselect, bus.write_n, bus.address, busy, tick_count, spurious_count);
        else n_pass++;
        m_ticks = 0;
        m_spur  = 0;
        en = 1'b0;
        cyc(2);
        reset = 1'b0;
        cyc(1);
        txq.delete();
        en = 1'b1;
        cyc(10);
        // the uncleared timeout is still pending and gets serviced after re-enable
        m_ticks++;
        n_checks++;
        if (txq.size() != 3 || txq[0] != '{a: 3'd1, wn: 1'b0, d: 16'd1} || txq[1].a != 3'd0 ||
            txq[1].wn != 1'b1 || txq[2] != '{a: 3'd0, wn: 1'b0, d: 16'd0})
            $display("FAIL reenable_bus got ntx=%0d exp 3 (ctrl 1, read 0, clear)", txq.size());
        else n_pass++;
        n_checks++;
        if (tick_count !== 32'(m_ticks) || spurious_count !== 8'd0 || busy !== 1'b0)
            $display("FAIL reenable_cnt got tc=%0d sc=%0d busy=%b exp %0d 0 0",
                     tick_count, spurious_count, busy, m_ticks);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_enable();
        test_timeout();
        test_restart_collision();
        test_random_mix();
        test_spurious();
        test_disable();
        test_idle();
        test_reset_mid();
        n_checks++;
        if (cs_violations != 0) $display("FAIL single_cycle_cs got %0d back-to-back strobes exp 0", cs_violations);
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
